button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 16 +
 rtl/button_conditioner_if.sv | 27 ++
 rtl/btn_debounce.sv | 140 ++++++++++++++
 rtl/button_conditioner.sv | 70 +++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default constants for the button conditioner.
// BTN_AUTOREPEAT_EN enables held-button auto-repeat in btn_debounce.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_SETTLE,
        HELD,
        RELEASE_SETTLE
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 500000;
    localparam int DEF_REPEAT_RATE     = 100000;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned counter-control pulses.
// The master side drives the buttons; the slave side is the conditioner.
interface button_conditioner_if;

    logic btn_up_raw;
    logic btn_dn_raw;
    logic incr;
    logic decr;
    logic conflict;

    modport master (
        output btn_up_raw,
        output btn_dn_raw,
        input  incr,
        input  decr,
        input  conflict
    );

    modport slave (
        input  btn_up_raw,
        input  btn_dn_raw,
        output incr,
        output decr,
        output conflict
    );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM and settle counter.
// With BTN_AUTOREPEAT_EN defined, a repeat counter re-fires evt while HELD.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Leaving a settle state is decided on the sample that brings the count to CNT_LAST.
    localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 2);

    logic [1:0]    sync_q;
    logic          synced;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_evt;
    logic          enter_held;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign synced = sync_q[1];

    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        press_evt  = 1'b0;
        enter_held = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (synced) begin
                    state_d = PRESS_SETTLE;
                    cnt_d   = '0;
                end
            end
            PRESS_SETTLE: begin
                if (!synced) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_PRE) begin
                        state_d    = HELD;
                        press_evt  = 1'b1;
                        enter_held = 1'b1;
                    end
                end
            end
            HELD: begin
                if (!synced) begin
                    state_d = RELEASE_SETTLE;
                    cnt_d   = '0;
                end
            end
            RELEASE_SETTLE: begin
                if (synced) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_PRE) state_d = RELEASED;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_phase_q, rep_phase_d;
    logic          rep_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    // Phase 0 waits out the initial delay; phase 1 repeats at the steady rate.
    always_comb begin
        rep_d       = rep_q;
        rep_phase_d = rep_phase_q;
        rep_evt     = 1'b0;
        if (enter_held) begin
            rep_d       = '0;
            rep_phase_d = 1'b0;
        end else if (state_q == HELD && synced) begin
            if (rep_q == (rep_phase_q ? REP_NEXT : REP_FIRST)) begin
                rep_evt     = 1'b1;
                rep_d       = '0;
                rep_phase_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    assign evt = press_evt | rep_evt;
`else
    assign evt = press_evt;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces up/down buttons into one-cycle incr/decr pulses for an up/down counter.
// Coincident events are dropped and flagged on conflict. Macro: BTN_AUTOREPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave bus
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("button_conditioner: DEBOUNCE_CYCLES >= 2 and REPEAT_* >= 1 required");
    end

    logic up_evt;
    logic dn_evt;
    logic incr_q;
    logic decr_q;
    logic conflict_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
`endif
    ) u_up (
        .clk (clk),
        .rst (rst),
        .raw (bus.btn_up_raw),
        .evt (up_evt)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
`endif
    ) u_dn (
        .clk (clk),
        .rst (rst),
        .raw (bus.btn_dn_raw),
        .evt (dn_evt)
    );

    // A coincident pair cancels out; the downstream counter sees neither.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            incr_q     <= 1'b0;
            decr_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            incr_q     <= up_evt & ~dn_evt;
            decr_q     <= dn_evt & ~up_evt;
            conflict_q <= up_evt & dn_evt;
        end
    end

    assign bus.incr     = incr_q;
    assign bus.decr     = decr_q;
    assign bus.conflict = conflict_q;

endmodule
